// File: rtl/smod_pkg.sv
// Shared field layout and gate-mode encoding for the S-module cell array.
// Per-lane config field: {invert, bypass, mode[SEL_BITS-1:0]}.
package smod_pkg;

  typedef enum logic {
    GATE_AND = 1'b0,
    GATE_OR  = 1'b1
  } gate_mode_e;

  localparam int MODE_LSB = 0;

  function automatic int cfg_field_w(input int sel_bits);
    return sel_bits + 2;
  endfunction

  function automatic int bypass_ofs(input int sel_bits);
    return sel_bits;
  endfunction

  function automatic int invert_ofs(input int sel_bits);
    return sel_bits + 1;
  endfunction

endpackage

// File: rtl/smod_lane.sv
// One cell: gated select, 2^SEL_BITS:1 mux, invert, output flop; 1-cycle latency or 0 when bypassed.
// No backpressure; ce freezes the output flop.
module smod_lane
  import smod_pkg::*;
#(
  parameter int SEL_BITS = 2
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic                               ce,
  input  logic [(1<<SEL_BITS)-1:0]           d,
  input  logic [SEL_BITS-1:0]                a,
  input  logic [SEL_BITS-1:0]                b,
  input  logic [cfg_field_w(SEL_BITS)-1:0]   cfg,
  output logic                               out
);

  localparam int BYPASS_OFS = bypass_ofs(SEL_BITS);
  localparam int INVERT_OFS = invert_ofs(SEL_BITS);

  logic [SEL_BITS-1:0] sel;
  logic                r;
  logic                q;
  gate_mode_e          mode;

  always_comb begin
    sel  = '0;
    mode = GATE_AND;
    for (int i = 0; i < SEL_BITS; i++) begin
      mode   = gate_mode_e'(cfg[MODE_LSB+i]);
      sel[i] = (mode == GATE_OR) ? (a[i] | b[i]) : (a[i] & b[i]);
    end
  end

  assign r = d[sel] ^ cfg[INVERT_OFS];

  // q keeps tracking r while bypassed so leaving bypass shows a fresh capture
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= 1'b0;
    end else if (ce) begin
      q <= r;
    end
  end

  assign out = cfg[BYPASS_OFS] ? r : q;

endmodule

// File: rtl/smod_cell_array.sv
// LANES independent S-module cells with a serially loaded, double-buffered config chain.
// Output latency 1 cycle (0 in bypass); no backpressure, cfg_commit rejected (cfg_err) until a full frame is shifted.
module smod_cell_array
  import smod_pkg::*;
#(
  parameter int SEL_BITS = 2,
  parameter int LANES    = 4
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            ce,
  input  logic [LANES*(1<<SEL_BITS)-1:0]  d,
  input  logic [LANES*SEL_BITS-1:0]       a,
  input  logic [LANES*SEL_BITS-1:0]       b,
  input  logic                            cfg_en,
  input  logic                            cfg_in,
  input  logic                            cfg_commit,
  output logic                            cfg_out,
  output logic                            cfg_ready,
  output logic                            cfg_err,
  output logic [LANES-1:0]                out
);

  localparam int DW      = 1 << SEL_BITS;
  localparam int FW      = cfg_field_w(SEL_BITS);
  localparam int CFG_LEN = LANES * FW;
  localparam int CW      = $clog2(CFG_LEN + 1);

  logic [CFG_LEN-1:0] sr;
  logic [CFG_LEN-1:0] active;
  logic [CW-1:0]      cnt;
  logic               err;
  logic               commit_ok;

  assign cfg_ready = (cnt == CW'(CFG_LEN));
  assign commit_ok = cfg_commit & cfg_ready;
  assign cfg_out   = sr[CFG_LEN-1];
  assign cfg_err   = err;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr <= '0;
    end else if (cfg_en) begin
      sr <= {sr[CFG_LEN-2:0], cfg_in};
    end
  end

  // Active config takes the pre-shift frame even when a shift lands on the same edge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      active <= '0;
      err    <= 1'b0;
    end else if (cfg_commit) begin
      if (cfg_ready) begin
        active <= sr;
      end else begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (commit_ok) begin
      cnt <= cfg_en ? CW'(1) : '0;
    end else if (cfg_en && !cfg_ready) begin
      cnt <= cnt + CW'(1);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    smod_lane #(
      .SEL_BITS(SEL_BITS)
    ) u_lane (
      .clk (clk),
      .clr (clr),
      .ce  (ce),
      .d   (d[l*DW +: DW]),
      .a   (a[l*SEL_BITS +: SEL_BITS]),
      .b   (b[l*SEL_BITS +: SEL_BITS]),
      .cfg (active[l*FW +: FW]),
      .out (out[l])
    );
  end

endmodule

// File: tb/tb_smod_cell_array.sv
// Directed bench for smod_cell_array with a queue-based reference model checked every cycle.
module tb_smod_cell_array;

  localparam int S   = 2;
  localparam int L   = 4;
  localparam int M   = 1 << S;
  localparam int F   = S + 2;
  localparam int LEN = L * F;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic            ce = 1'b0;
  logic [L*M-1:0]  d = '0;
  logic [L*S-1:0]  a = '0;
  logic [L*S-1:0]  b = '0;
  logic            cfg_en = 1'b0;
  logic            cfg_in = 1'b0;
  logic            cfg_commit = 1'b0;
  logic            cfg_out;
  logic            cfg_ready;
  logic            cfg_err;
  logic [L-1:0]    out;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  smod_cell_array #(
    .SEL_BITS(S),
    .LANES   (L)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .ce        (ce),
    .d         (d),
    .a         (a),
    .b         (b),
    .cfg_en    (cfg_en),
    .cfg_in    (cfg_in),
    .cfg_commit(cfg_commit),
    .cfg_out   (cfg_out),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .out       (out)
  );

  // Reference model: shifted bits kept as a history queue, newest at the back
  bit             shq[$];
  int             mcnt = 0;
  logic [LEN-1:0] mact = '0;
  logic           mq[L];
  logic           merr = 1'b0;

  function automatic logic [LEN-1:0] sr_vec();
    logic [LEN-1:0] v;
    v = '0;
    for (int k = 0; k < LEN; k++)
      if (k < shq.size()) v[k] = shq[shq.size()-1-k];
    return v;
  endfunction

  function automatic logic r_lane(int ln);
    int s;
    logic ai, bi, bitv;
    s = 0;
    for (int i = 0; i < S; i++) begin
      ai   = a[ln*S+i];
      bi   = b[ln*S+i];
      bitv = mact[ln*F+i] ? (ai | bi) : (ai & bi);
      if (bitv) s += (1 << i);
    end
    return d[ln*M+s] ^ mact[ln*F+S+1];
  endfunction

  function automatic logic exp_out(int ln);
    return mact[ln*F+S] ? r_lane(ln) : mq[ln];
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      shq.delete();
      mcnt = 0;
      mact = '0;
      merr = 1'b0;
      for (int l = 0; l < L; l++) mq[l] = 1'b0;
    end else begin
      automatic bit rdy = (mcnt == LEN);
      if (ce) for (int l = 0; l < L; l++) mq[l] = r_lane(l);
      if (cfg_commit) begin
        if (rdy) mact = sr_vec();
        else     merr = 1'b1;
      end
      if (cfg_en) begin
        shq.push_back(cfg_in);
        if (shq.size() > LEN) void'(shq.pop_front());
      end
      if (cfg_commit && rdy) mcnt = cfg_en ? 1 : 0;
      else if (cfg_en && mcnt < LEN) mcnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !clr) begin
      for (int l = 0; l < L; l++) check($sformatf("model_out%0d", l), 32'(out[l]), 32'(exp_out(l)));
      check("model_ready", 32'(cfg_ready), 32'(mcnt == LEN));
      check("model_err", 32'(cfg_err), 32'(merr));
      check("model_cfg_out", 32'(cfg_out), 32'((shq.size() == LEN) ? shq[0] : 1'b0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [LEN-1:0] w);
    cfg_en = 1'b1;
    for (int i = LEN-1; i >= 0; i--) begin
      cfg_in = w[i];
      tick();
    end
    cfg_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic lane0(input logic [3:0] dv, input logic [1:0] av, input logic [1:0] bv);
    d[3:0] = dv;
    a[1:0] = av;
    b[1:0] = bv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:31] patv;
    patv = 32'b1011_0010_1110_0001_1001_1100_0101_0101;

    // 1: reset defaults, AND gating
    tick();
    check("rst_out", 32'(out), 32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    clr = 1'b0;
    chk_on = 1'b1;
    ce = 1'b1;
    lane0(4'b0110, 2'b11, 2'b11);
    tick();
    check("t1_and_sel3", 32'(out[0]), 32'h0);
    lane0(4'b0110, 2'b11, 2'b10);
    tick();
    check("t1_and_sel2", 32'(out[0]), 32'h1);

    // 2: load lane0 OR mode
    shift_word(16'h0003);
    check("t2_ready16", 32'(cfg_ready), 32'h1);
    commit();
    check("t2_ready_after_commit", 32'(cfg_ready), 32'h0);
    lane0(4'b0110, 2'b01, 2'b00);
    d[7:4] = 4'b1000;  a[3:2] = 2'b11; b[3:2] = 2'b01;
    d[11:8] = 4'b0100; a[5:4] = 2'b11; b[5:4] = 2'b10;
    tick();
    check("t2_or_sel1", 32'(out[0]), 32'h1);
    check("t2_lane1_and", 32'(out[1]), 32'h0);
    check("t2_lane2_and", 32'(out[2]), 32'h1);

    // 3: early commit from a clean state
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cfg_en = 1'b1;
    for (int i = 15; i >= 6; i--) begin
      cfg_in = (i < 2);
      tick();
    end
    cfg_en = 1'b0;
    commit();
    check("t3_err_early", 32'(cfg_err), 32'h1);
    lane0(4'b0110, 2'b01, 2'b00);
    tick();
    check("t3_still_and", 32'(out[0]), 32'h0);
    cfg_en = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      cfg_in = (i < 2);
      tick();
    end
    cfg_en = 1'b0;
    commit();
    check("t3_ready_cleared", 32'(cfg_ready), 32'h0);
    check("t3_err_sticky", 32'(cfg_err), 32'h1);
    tick();
    check("t3_now_or", 32'(out[0]), 32'h1);

    // 4: bypass + invert, combinational with ce=0
    shift_word(16'h000C);
    commit();
    lane0(4'b0110, 2'b00, 2'b00);
    tick();
    check("t4_byp_sel0", 32'(out[0]), 32'h1);
    ce = 1'b0;
    lane0(4'b0110, 2'b01, 2'b01);
    #1 check("t4_byp_sel1", 32'(out[0]), 32'h0);
    lane0(4'b0110, 2'b11, 2'b11);
    #1 check("t4_byp_sel3", 32'(out[0]), 32'h1);
    lane0(4'b0110, 2'b01, 2'b01);
    #1 check("t4_byp_sel1_again", 32'(out[0]), 32'h0);
    shift_word(16'h0008);
    commit();
    check("t4_frozen_q", 32'(out[0]), 32'h1);

    // 5: hold with ce=0, then async clear between edges
    ce = 1'b1;
    lane0(4'b0110, 2'b00, 2'b00);
    tick();
    check("t5_reg_inv", 32'(out[0]), 32'h1);
    ce = 1'b0;
    d[3:0] = 4'b1111;
    tick();
    tick();
    check("t5_hold", 32'(out[0]), 32'h1);
    #1 clr = 1'b1;
    #1;
    check("t5_async_out", 32'(out), 32'h0);
    check("t5_async_err", 32'(cfg_err), 32'h0);
    check("t5_async_ready", 32'(cfg_ready), 32'h0);
    tick();
    clr = 1'b0;
    ce = 1'b1;
    lane0(4'b0111, 2'b01, 2'b00);
    tick();
    check("t5_cfg_zeroed", 32'(out[0]), 32'h1);

    // 6: chain passthrough, then simultaneous shift+commit
    cfg_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cfg_in = patv[i];
      tick();
      if (i == 14) check("t6_ready_15", 32'(cfg_ready), 32'h0);
      if (i >= 15) check($sformatf("t6_cfg_out%0d", i), 32'(cfg_out), 32'(patv[i-15]));
    end
    cfg_in = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    cfg_en = 1'b0;
    check("t6_sim_ready", 32'(cfg_ready), 32'h0);
    lane0(4'b0110, 2'b01, 2'b00);
    #1 check("t6_presheft_cfg", 32'(out[0]), 32'h1);
    cfg_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cfg_in = i[0];
      tick();
      if (i == 13) check("t6_cnt_from1_not", 32'(cfg_ready), 32'h0);
    end
    cfg_en = 1'b0;
    check("t6_cnt_from1_ready", 32'(cfg_ready), 32'h1);
    commit();
    cfg_en = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_en = 1'b0;
    cfg_commit = 1'b0;
    check("t6_sim_err", 32'(cfg_err), 32'h1);
    tick();

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
